// File: rtl/cntr_pkg.sv
// Shared definitions for the counter-loader slice.
// Holds the loader FSM state type, default widths and the next-count helper.
// No logic and no latency; the package is imported by every file in the slice.
package cntr_pkg;

  localparam int CNTR_WIDTH_DFLT  = 4;
  localparam int CNTR_WRAP_W_DFLT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } cntr_ld_state_t;

  // Value a wrap counter must show one cycle after showing 'prev'.
  // The counter reloads 'val' after its maximum, so the result never overflows.
  // 'width' must be below 32.
  function automatic logic [31:0] cntr_next(input logic [31:0] prev,
                                            input logic [31:0] val,
                                            input int          width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (prev == max_v) begin
      return val;
    end
    return prev + 32'd1;
  endfunction

endpackage

// File: rtl/cntr_loader_if.sv
// Request channel into cntr_loader: start value plus wrap count, valid/ready.
// Combinational wiring only, so the channel itself adds no latency.
// A request waits with req_valid held until the loader raises req_ready.
// Ports: req_valid/req_val/req_wraps come from the master, req_ready from the slave.
interface cntr_loader_if
  import cntr_pkg::*;
#(
  parameter int WIDTH  = CNTR_WIDTH_DFLT,
  parameter int WRAP_W = CNTR_WRAP_W_DFLT
) ();

  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  req_val;
  logic [WRAP_W-1:0] req_wraps;

  modport master (
    output req_valid,
    output req_val,
    output req_wraps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_val,
    input  req_wraps,
    output req_ready
  );

endinterface

// File: rtl/cntr_seq_mon.sv
// Sequence monitor: tracks the counter output after a load, flags wraps and bad values.
// wrap/mismatch are combinational from count_in; prev_q registers once per cycle.
// No backpressure; it follows the counter every cycle while chk_en or run_en is high.
// Ports: clk, rst; chk_en (CHECK state), run_en (RUN state), val (loaded value),
//        count_in (counter output) -> wrap, mismatch.
// The value comparator only exists when CNTR_LOADER_CHECK_EN is defined.
module cntr_seq_mon
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_WIDTH_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             run_en,
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] count_in,
  output logic             wrap,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] MAX_V = '1;

  logic [WIDTH-1:0] prev_q;

  // In CHECK this captures the loaded value; in RUN it follows the counter even
  // after a bad value, so wrap detection resynchronises to what the counter shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else if (chk_en || run_en) begin
      prev_q <= count_in;
    end
  end

  // A wrap is the step from max back to the reload value. When val == max the
  // counter sits at max, so every RUN cycle counts as a wrap.
  assign wrap = run_en && (prev_q == MAX_V) && (count_in == val);

`ifdef CNTR_LOADER_CHECK_EN
  logic [WIDTH-1:0] exp_cnt;

  // CHECK expects the freshly loaded value; RUN expects the successor of prev_q.
  assign exp_cnt  = chk_en ? val
                           : WIDTH'(cntr_next(32'(prev_q), 32'(val), WIDTH));
  assign mismatch = (chk_en || run_en) && (count_in != exp_cnt);
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: rtl/cntr_loader.sv
// Load initiator for a wrap counter: loads it, confirms the load, counts wraps, pulses done.
// Latency: ld_in one cycle after accept; done three cycles after accept with zero wraps.
// Backpressure: req_ready only in IDLE; a request raised while busy waits, it is not consumed.
// Ports: clk, rst (sync, active high); req (cntr_loader_if slave: valid/ready, val, wraps);
//        ld_in/ld_val to the counter; count_in from it; busy, done, wraps_seen, err status.
// Build option: CNTR_LOADER_CHECK_EN adds value checking; without it err is tied to 0.
module cntr_loader
  import cntr_pkg::*;
#(
  parameter int WIDTH  = CNTR_WIDTH_DFLT,
  parameter int WRAP_W = CNTR_WRAP_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  cntr_loader_if.slave      req,
  output logic              ld_in,
  output logic [WIDTH-1:0]  ld_val,
  input  logic [WIDTH-1:0]  count_in,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps_seen,
  output logic              err
);

  cntr_ld_state_t    state;
  logic [WIDTH-1:0]  val_q;
  logic [WRAP_W-1:0] tgt_q;
  logic [WRAP_W-1:0] wraps_inc;
  logic              accept;
  logic              chk_en;
  logic              run_en;
  logic              wrap;
  logic              mismatch;
  logic              last_wrap;

  // Held low through reset even though the state register may already read IDLE.
  assign req.req_ready = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);
  assign accept        = req.req_ready && req.req_valid;

  assign chk_en = (state == CHECK);
  assign run_en = (state == RUN);

  // val_q is a register, so ld_val stays defined (and 0 out of reset) between loads.
  assign ld_val = val_q;

  // Saturating increment; tgt_q cannot exceed all-ones, so the job ends first.
  assign wraps_inc = (wraps_seen == '1) ? wraps_seen : wraps_seen + WRAP_W'(1);
  assign last_wrap = wrap && (wraps_inc == tgt_q);

  cntr_seq_mon #(
    .WIDTH (WIDTH)
  ) u_seq_mon (
    .clk      (clk),
    .rst      (rst),
    .chk_en   (chk_en),
    .run_en   (run_en),
    .val      (val_q),
    .count_in (count_in),
    .wrap     (wrap),
    .mismatch (mismatch)
  );

  // Control FSM. ld_in and done are pulses registered on entry to LOAD and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      val_q      <= '0;
      tgt_q      <= '0;
      ld_in      <= 1'b0;
      done       <= 1'b0;
      wraps_seen <= '0;
    end else begin
      ld_in <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            val_q      <= req.req_val;
            tgt_q      <= req.req_wraps;
            wraps_seen <= '0;
            ld_in      <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          state <= CHECK;
        end
        CHECK: begin
          if (mismatch || (tgt_q == '0)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (mismatch) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (wrap) begin
            wraps_seen <= wraps_inc;
            if (last_wrap) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CNTR_LOADER_CHECK_EN
  logic err_q;

  // Sticky until the next accepted request; mismatch is only raised in CHECK/RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cntr_loader.sv
// Bench for cntr_loader: directed requests against a behavioural wrap counter,
// a timeline model of the expected outputs checked every cycle, and literal checks.
module tb_cntr_loader;

  localparam int W  = 4;
  localparam int WW = 8;
`ifdef CNTR_LOADER_CHECK_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_in;
  logic [W-1:0]  ld_val;
  logic          busy;
  logic          done;
  logic [WW-1:0] wraps_seen;
  logic          err;
  logic [W-1:0]  cnt = '0;
  logic [W-1:0]  rld = '0;
  logic          inject = 1'b0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  cntr_loader_if #(.WIDTH(W), .WRAP_W(WW)) ifc ();

  cntr_loader #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (ifc),
    .ld_in      (ld_in),
    .ld_val     (ld_val),
    .count_in   (cnt),
    .busy       (busy),
    .done       (done),
    .wraps_seen (wraps_seen),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Loadable wrap counter; with 'inject' set it skips from 6 straight to 8.
  always @(posedge clk) begin
    if (ld_in) begin
      cnt <= ld_val;
      rld <= ld_val;
    end else if (cnt == 4'hF) begin
      cnt <= rld;
    end else if (inject && cnt == 4'h6) begin
      cnt <= 4'h8;
    end else begin
      cnt <= cnt + 4'h1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // A job accepted in cycle ta shows its loaded value at ta+2; every P cycles after
  // that the counter returns to the load value (a wrap), visible in wraps_seen one
  // cycle later. done lands the cycle after the last wrap (or after the mismatch).
  bit have_job = 0;
  bit j_err    = 0;
  bit m_busy;
  int j_ta, j_done, j_p, j_nw, j_mc, j_val, m_tgt;

  function automatic int ws_at(input int c);
    int n;
    n = 0;
    if (have_job) begin
      for (int k = 1; k <= j_nw; k++) begin
        if (j_ta + 2 + k * j_p < c) n++;
      end
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", 32'(ifc.req_ready), 0);
      have_job = 0;
    end else begin
      m_busy = have_job && cyc > j_ta && cyc <= j_done;
      chk("ready",  32'(ifc.req_ready), m_busy ? 0 : 1);
      chk("busy",   32'(busy),          m_busy ? 1 : 0);
      chk("ld_in",  32'(ld_in),         (have_job && cyc == j_ta + 1) ? 1 : 0);
      chk("done",   32'(done),          (have_job && cyc == j_done) ? 1 : 0);
      chk("ld_val", 32'(ld_val),        have_job ? j_val : 0);
      chk("wraps",  32'(wraps_seen),    ws_at(cyc));
      chk("err",    32'(err),           (have_job && j_err && cyc > j_mc) ? 1 : 0);
      if (ifc.req_valid && !m_busy) begin
        have_job = 1;
        j_ta     = cyc;
        j_val    = int'(ifc.req_val);
        m_tgt    = int'(ifc.req_wraps);
        if (j_val == 15)                 j_p = 1;
        else if (inject && j_val <= 6)   j_p = 15 - j_val;
        else                             j_p = 16 - j_val;
        j_err = (CHK_EN == 1) && inject && j_val <= 6 && m_tgt > 0;
        if (j_err) begin
          // 8 appears where 7 was due, before the count ever reaches max.
          j_mc   = j_ta + 2 + (7 - j_val);
          j_done = j_mc + 1;
          j_nw   = 0;
        end else begin
          j_mc   = 0;
          j_nw   = m_tgt;
          j_done = (m_tgt == 0) ? j_ta + 3 : j_ta + 3 + m_tgt * j_p;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept(output int ta);
    ta = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.req_ready && ifc.req_valid) begin
        ta = cyc;
        break;
      end
    end
    if (ta < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout cyc=%0d got=no_done exp=done", cyc);
    end
  endtask

  task automatic do_req(input logic [W-1:0] v, input logic [WW-1:0] w, output int ta);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b1;
    ifc.req_val   = v;
    ifc.req_wraps = w;
    wait_accept(ta);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
  endtask

  initial begin
    int ta, ta2, dc;
    ifc.req_valid = 1'b0;
    ifc.req_val   = '0;
    ifc.req_wraps = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ifc.req_ready), 1);
    chk("post_rst_ldval", 32'(ld_val), 0);
    chk("post_rst_busy",  32'(busy), 0);

    // Two wraps from 3: 3..F,3..F,3 then done.
    do_req(4'h3, 8'd2, ta);
    wait_done(dc);
    chk("t1_latency", 32'(dc - ta), 29);
    chk("t1_wraps",   32'(wraps_seen), 2);
    chk("t1_err",     32'(err), 0);

    // Zero wraps: minimum latency.
    do_req(4'hA, 8'd0, ta);
    wait_done(dc);
    chk("t2_latency", 32'(dc - ta), 3);
    chk("t2_wraps",   32'(wraps_seen), 0);

    // Load value at max: every RUN cycle is a wrap.
    do_req(4'hF, 8'd5, ta);
    wait_done(dc);
    chk("t3_latency", 32'(dc - ta), 8);
    chk("t3_wraps",   32'(wraps_seen), 5);

    // Counter skips 6 -> 8.
    inject = 1'b1;
    do_req(4'h0, 8'd1, ta);
    wait_done(dc);
    chk("t4_latency", 32'(dc - ta), (CHK_EN == 1) ? 10 : 18);
    chk("t4_err",     32'(err), CHK_EN);
    repeat (3) @(negedge clk);
    chk("t4_err_hold", 32'(err), CHK_EN);
    inject = 1'b0;
    do_req(4'h2, 8'd0, ta);
    chk("t4_err_clr", 32'(err), 0);
    wait_done(dc);

    // Reset in RUN after the first wrap.
    do_req(4'h3, 8'd2, ta);
    while (cyc < ta + 18) @(negedge clk);
    chk("t5_wraps_pre", 32'(wraps_seen), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_ld_in", 32'(ld_in), 0);
    chk("t5_wraps", 32'(wraps_seen), 0);
    chk("t5_ready", 32'(ifc.req_ready), 1);
    chk("t5_done",  32'(done), 0);
    repeat (20) @(negedge clk);

    // Request held through a running job with new contents.
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b1;
    ifc.req_val   = 4'h5;
    ifc.req_wraps = 8'd1;
    wait_accept(ta);
    @(posedge clk);
    #1;
    ifc.req_val   = 4'h9;
    ifc.req_wraps = 8'd0;
    wait_accept(ta2);
    chk("t6_gap", 32'(ta2 - ta), 15);
    @(posedge clk);
    #1 ifc.req_valid = 1'b0;
    wait_done(dc);
    chk("t6_latency", 32'(dc - ta2), 3);
    chk("t6_ldval",   32'(ld_val), 9);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
